// File: rtl/mul_madd_unit.sv
// Iterative multiply / multiply-accumulate unit with architectural HI/LO registers.
// Optional zero-operand early exit when MUL_EARLY_EXIT_EN is defined.
module mul_madd_unit #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int N  = XLEN / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * XLEN;

  localparam logic [2:0] OP_MTHI   = 3'd4;
  localparam logic [2:0] OP_MTLO   = 3'd5;
  localparam logic [2:0] OP_CLRACC = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, ACC} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              accum_q, accum_d;

  // Shift-add partial product for the current STEP-bit multiplier digit.
  logic [PW-1:0]     pp_terms [STEP];
  logic [PW-1:0]     partial;

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_pp
      assign pp_terms[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
    end
  endgenerate

  always_comb begin
    partial = '0;
    for (int i = 0; i < STEP; i++) begin
      partial = partial + pp_terms[i];
    end
  end

  logic              is_signed;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [PW-1:0]     result;
  logic [PW-1:0]     acc_sum;

  // Signed ops take magnitudes; the most negative value maps to its unsigned magnitude.
  assign is_signed = ~op[0];
  assign a_mag     = (is_signed && a[XLEN-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (is_signed && b[XLEN-1]) ? (~b + 1'b1) : b;
  assign result    = sign_q ? (~prod_q + 1'b1) : prod_q;
  assign acc_sum   = {hi_q, lo_q} + result;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    accum_d  = accum_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[2]) begin
            mcand_d  = {{XLEN{1'b0}}, a_mag};
            mplier_d = b_mag;
            sign_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            accum_d  = op[1];
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = CALC;
`ifdef MUL_EARLY_EXIT_EN
            if ((a == '0) || (b == '0)) begin
              sign_d  = 1'b0;
              state_d = ACC;
            end
`endif
          end else begin
            case (op)
              OP_MTHI:   hi_d = a;
              OP_MTLO:   lo_d = a;
              OP_CLRACC: begin
                hi_d = '0;
                lo_d = '0;
              end
              default: ;
            endcase
            done_d = 1'b1;
          end
        end
      end
      CALC: begin
        prod_d   = prod_q + partial;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d = ACC;
        end
      end
      ACC: begin
        if (accum_q) begin
          {hi_d, lo_d} = acc_sum;
        end else begin
          {hi_d, lo_d} = result;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      accum_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      accum_q  <= accum_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_madd_unit.sv
// Scoreboard bench for mul_madd_unit: stimulus pushes expected HI/LO and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mul_madd_unit;

  localparam int XLEN = 32;
  localparam int STEP = 4;
  localparam int MLAT = XLEN / STEP + 2;
`ifdef MUL_EARLY_EXIT_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = MLAT;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  mul_madd_unit #(.XLEN(XLEN), .STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    int              cyc;
    string           name;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'(cyc), 64'(-1));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        $display("txn %s: hi=0x%08h lo=0x%08h cycle=%0d", e.name, hi, lo, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in the current cycle (busy must be 0), then scramble inputs.
  task automatic issue(input string nm, input logic [2:0] o, input logic [XLEN-1:0] av,
                       input logic [XLEN-1:0] bv, input bit push,
                       input logic [XLEN-1:0] eh, input logic [XLEN-1:0] el, input int lat);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (push) begin
      e.hi   = eh;
      e.lo   = el;
      e.cyc  = cyc + lat;
      e.name = nm;
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle(input string nm);
    int i;
    for (i = 0; i < 60; i++) begin
      if (!busy) break;
      tick();
    end
    if (busy) chk({nm, "_idle_timeout"}, 64'(busy), 64'(0));
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic [XLEN-1:0] av,
                     input logic [XLEN-1:0] bv, input logic [XLEN-1:0] eh,
                     input logic [XLEN-1:0] el, input int lat);
    issue(nm, o, av, bv, 1'b1, eh, el, lat);
    wait_idle(nm);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi",   64'(hi),   64'(0));
    chk("reset_lo",   64'(lo),   64'(0));

    run("mul_neg3x7",   3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MLAT);
    run("mulu_max",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MLAT);
    run("mul_m1xm1",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MLAT);
    run("mthi",         3'd4, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000001, 1);
    run("mtlo",         3'd5, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF, 1);
    run("madd_carry",   3'd2, 32'd1,        32'd1,        32'h00000001, 32'h00000000, MLAT);
    run("maddu",        3'd3, 32'h80000000, 32'd2,        32'h00000002, 32'h00000000, MLAT);
    run("madd_neg",     3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, MLAT);
    run("op7_nop",      3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 32'h00000001, 32'hFFFFFFFE, 1);
    run("clracc",       3'd6, 32'hDEADBEEF, 32'h0,        32'h00000000, 32'h00000000, 1);
    run("mul_minxmin",  3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MLAT);
    run("mul_maxxmin",  3'd0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, MLAT);

    // Start while busy must be ignored entirely.
    issue("mul_ignore", 3'd0, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6, MLAT);
    tick();
    tick();
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd5;
    b     = 32'd5;
    tick();
    start = 1'b0;
    wait_idle("mul_ignore");
    repeat (3) tick();

    // Reset mid-operation: no done, HI/LO cleared.
    issue("mul_abort", 3'd0, 32'd2, 32'd3, 1'b0, 32'd0, 32'd0, 0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hi",   64'(hi),   64'(0));
    chk("abort_lo",   64'(lo),   64'(0));
    repeat (12) tick();

    run("mul_4x4",      3'd0, 32'd4,        32'd4,        32'h00000000, 32'd16,       MLAT);
    run("mul_zero",     3'd0, 32'd0,        32'd9,        32'h00000000, 32'h00000000, ZLAT);
    run("mtlo_pre",     3'd5, 32'h00000005, 32'h0,        32'h00000000, 32'h00000005, 1);
    run("madd_zero",    3'd2, 32'd7,        32'd0,        32'h00000000, 32'h00000005, ZLAT);

    repeat (5) tick();
    chk("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mul_madd_unit.md
Name: mul_madd_unit

Overview:
- Iterative multi-cycle integer multiply / multiply-accumulate unit with architectural HI/LO registers.
- Sits beside the integer ALU in the processor datapath. Executes MUL, MULU, MADD, MADDU, MTHI, MTLO and accumulator clear.
- Generalises the datapath's combinational multiply in operand width and bits retired per cycle.
- Holds HI/LO state across instructions, so MADD/MADDU accumulate correctly.

Parameters:
- XLEN, 32, operand width; HI and LO are each XLEN bits; product is 2*XLEN.
- STEP, 4, multiplier bits retired per CALC cycle; legal values 1, 2, 4, 8; XLEN % STEP == 0.

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy==0
- op  input  3  0 MUL, 1 MULU, 2 MADD, 3 MADDU, 4 MTHI, 5 MTLO, 6 CLRACC, 7 reserved
- a  input  XLEN  operand A (rs); also MTHI/MTLO source
- b  input  XLEN  operand B (rt)
- busy  output  1  multi-cycle op in flight
- done  output  1  one-cycle pulse; HI/LO valid in the same cycle
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register; integer writeback source for mul

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high; no asynchronous reset.
- Reset values: hi=0, lo=0, busy=0, done=0, FSM=IDLE.
- Reset mid-operation aborts the op: no done pulse, HI/LO cleared.
- FSM states: IDLE, CALC, ACC.
- Let N = XLEN/STEP. Below, the accept cycle is T: start=1 and busy=0.
- Single-cycle ops (4, 5, 6, 7), register updates at the edge ending T:
  - MTHI: hi<=a.
  - MTLO: lo<=a.
  - CLRACC: hi<=0 and lo<=0.
  - op 7: no register change.
  - done=1 in T+1; busy stays 0; FSM stays IDLE.
- Multiply ops (0-3), IDLE -> CALC at the edge ending T; operands latched.
  - Signed ops (0, 2): latch magnitudes |a|, |b| and sign = a[XLEN-1]^b[XLEN-1].
  - Unsigned ops (1, 3): operands used raw; sign=0.
  - The most negative value's magnitude is represented in XLEN bits unsigned.
- CALC:
  - Each cycle adds (mcand * multiplier[STEP-1:0]) << shift into a 2*XLEN partial product, then shifts the multiplier right by STEP.
  - A cycle counter counts N cycles, then CALC -> ACC.
- ACC (one cycle):
  - If sign=1, negate the partial product (two's complement, 2*XLEN).
  - MUL/MULU: {hi,lo} <= product.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + product, modulo 2^(2*XLEN); carry propagates lo->hi; overflow discarded.
  - Then ACC -> IDLE.
- Timing: busy=1 in cycles T+1..T+N+1; done=1 in cycle T+N+2; busy=0 in that cycle.
- Defaults (XLEN=32, STEP=4): done 10 cycles after the start cycle.
- start while busy=1 is ignored: not queued, no side effect.
- start in the done cycle is accepted (busy=0 there).
- a/b/op changes after acceptance have no effect.
- hi/lo hold their previous values throughout CALC and change only at the ACC edge.

Optional Feature:
- Macro: MUL_EARLY_EXIT_EN.
- Defined: for multiply ops, if latched a==0 or b==0, IDLE -> ACC directly with product=0.
  - busy=1 in T+1 only; done=1 in T+2.
  - MADD/MADDU still writes {hi,lo} unchanged (+0).
- Undefined: zero operands take the full N-cycle CALC path; timing is data-independent.

Test Plan:
- MUL a=0xFFFFFFFD (-3), b=7 -> done in T+10; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MUL with the same operands -> hi=0, lo=1.
- MTHI a=0; MTLO a=0xFFFFFFFF (done=1 the cycle after each); then MADD a=1, b=1 -> hi=0x00000001, lo=0x00000000. Then MADDU a=0x80000000, b=2 -> hi=0x00000002, lo=0.
- MUL a=2, b=3 accepted at T; start with MUL a=5, b=5 at T+3 -> single done at T+10, lo=6, hi=0; no second done.
- MUL 2*3 started; rst=1 in T+4 -> T+5: busy=0, hi=lo=0; done never pulses; a following MUL 4*4 -> lo=16.
- MUL a=0, b=9 -> with MUL_EARLY_EXIT_EN: done at T+2, hi=lo=0; without: done at T+10.
